// File: rtl/par_to_ser_pkg.sv
// Shared types and sizing helpers for the par_to_ser parallel-to-serial converter.
package par_to_ser_pkg;

  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned SERIAL_LEN_DEF = 8;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Bits needed to hold a frame-bit count of 0..frame_len.
  function automatic int unsigned cnt_width(input int unsigned frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/par_to_ser_if.sv
// Producer-side bus of par_to_ser: load strobe, parallel word and serial/status returns.
interface par_to_ser_if #(
  parameter int unsigned DATA_W = par_to_ser_pkg::DATA_W_DEF
);

  logic              load;
  logic [DATA_W-1:0] parallel_in;
  logic              serial_out;
  logic              busy;
  logic              done;

  modport master (
    output load,
    output parallel_in,
    input  serial_out,
    input  busy,
    input  done
  );

  modport slave (
    input  load,
    input  parallel_in,
    output serial_out,
    output busy,
    output done
  );

endinterface

// File: rtl/par_to_ser_shreg.sv
// Loadable left-shift register; tap is the MSB the register will present after the next shift.
module par_to_ser_shreg
  import par_to_ser_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic              tap
);

  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] q_shl;

  assign q_shl = q << 1;
  assign tap   = q_shl[DATA_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= q_shl;
    end
  end

endmodule

// File: rtl/par_to_ser.sv
// Parallel-to-serial converter, MSB first, with busy/done pacing status.
// Optional even-parity trailer bit enabled by defining PAR_TO_SER_PARITY_EN.
module par_to_ser
  import par_to_ser_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned SERIAL_LEN = SERIAL_LEN_DEF
) (
  input  logic         clk,
  input  logic         rst,
  par_to_ser_if.slave  bus
);

`ifdef PAR_TO_SER_PARITY_EN
  localparam int unsigned FRAME_LEN = SERIAL_LEN + 1;
`else
  localparam int unsigned FRAME_LEN = SERIAL_LEN;
`endif
  localparam int unsigned CNT_W = cnt_width(FRAME_LEN);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             serial_q;
  logic             busy_q;
  logic             done_q;
  logic             shreg_tap;
  logic             next_bit;

  par_to_ser_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (bus.load),
    .shift (state == SHIFT),
    .d     (bus.parallel_in),
    .tap   (shreg_tap)
  );

`ifdef PAR_TO_SER_PARITY_EN
  logic parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (bus.load) begin
      parity <= ^bus.parallel_in[DATA_W-1 -: SERIAL_LEN];
    end
  end

  // cnt==2 means the next cycle is the last one of the frame: the parity slot.
  always_comb begin
    next_bit = shreg_tap;
    if (cnt == CNT_W'(2)) begin
      next_bit = parity;
    end
  end
`else
  always_comb begin
    next_bit = shreg_tap;
  end
`endif

  // cnt holds the number of frame cycles remaining, including the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      serial_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.load) begin
      state    <= SHIFT;
      cnt      <= CNT_W'(FRAME_LEN);
      serial_q <= bus.parallel_in[DATA_W-1];
      busy_q   <= 1'b1;
      done_q   <= (FRAME_LEN == 1);
    end else begin
      case (state)
        SHIFT: begin
          if (cnt == CNT_W'(1)) begin
            state    <= IDLE;
            cnt      <= '0;
            serial_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
          end else begin
            cnt      <= cnt - CNT_W'(1);
            serial_q <= next_bit;
            done_q   <= (cnt == CNT_W'(2));
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          serial_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.serial_out = serial_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_par_to_ser.sv
// Self-checking bench for par_to_ser: directed frames plus randomized loads/resets against a frame-queue model.
module tb_par_to_ser;

  logic clk;
  logic rst;

  int unsigned n_checks;
  int unsigned n_bad;

  // Model: the bits still to be shown on serial_out, front = current bit.
  logic exp_q[$];

  par_to_ser_if #(.DATA_W(8)) bus ();

  par_to_ser #(
    .DATA_W     (8),
    .SERIAL_LEN (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic ld, input logic [7:0] d);
    if (rst) begin
      exp_q.delete();
    end else if (ld) begin
      exp_q.delete();
      for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef PAR_TO_SER_PARITY_EN
      exp_q.push_back(($countones(d) % 2) == 1);
`endif
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_outputs(input string tag);
    logic exp_ser, exp_busy, exp_done;
    exp_ser  = (exp_q.size() > 0) ? exp_q[0] : 1'b0;
    exp_busy = (exp_q.size() > 0);
    exp_done = (exp_q.size() == 1);
    check_eq({tag, ".ser"},  bus.serial_out, exp_ser);
    check_eq({tag, ".busy"}, bus.busy,       exp_busy);
    check_eq({tag, ".done"}, bus.done,       exp_done);
  endtask

  // Drive inputs for one cycle, advance the model at the edge, check 1 time unit later.
  task automatic cycle(input string tag, input logic ld, input logic [7:0] d);
    bus.load        = ld;
    bus.parallel_in = d;
    @(posedge clk);
    model_edge(ld, d);
    #1;
    check_outputs(tag);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check_eq({tag, ".rst_ser"},  bus.serial_out, 1'b0);
    check_eq({tag, ".rst_busy"}, bus.busy,       1'b0);
    check_eq({tag, ".rst_done"}, bus.done,       1'b0);
    cycle(tag, 1'b0, 8'h00);
    cycle(tag, 1'b1, 8'hFF);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] bits;
    int unsigned done_cnt;
    n_checks = 0;
    n_bad    = 0;
    rst             = 1'b1;
    bus.load        = 1'b0;
    bus.parallel_in = '0;

    // Reset state
    cycle("reset", 1'b0, 8'h00);
    cycle("reset", 1'b1, 8'h5A);
    rst = 1'b0;
    cycle("idle", 1'b0, 8'hFF);

    // Single frame 8'hA5, bitstream collected independently of the model
    bits = '0;
    cycle("a5", 1'b1, 8'hA5);
    bits = {bits[6:0], bus.serial_out};
    for (int i = 0; i < 7; i++) begin
      cycle("a5", 1'b0, 8'h3C);
      bits = {bits[6:0], bus.serial_out};
    end
    check_eq("a5.stream", bits, 8'hA5);
    check_eq("a5.last_done", bus.done, 1'b1);
    for (int i = 0; i < 3; i++) cycle("a5_tail", 1'b0, 8'h00);

    // Back-to-back: reload on the final bit cycle of 8'hF0
    done_cnt = 0;
    cycle("b2b", 1'b1, 8'hF0);
    for (int i = 0; i < 7; i++) begin
      cycle("b2b", 1'b0, 8'h00);
      done_cnt += bus.done;
    end
    cycle("b2b", 1'b1, 8'h0F);
    for (int i = 0; i < 9; i++) begin
      cycle("b2b", 1'b0, 8'h00);
      done_cnt += bus.done;
    end
    check_eq("b2b.done_cnt", done_cnt, 2);

    // Mid-frame reload: three 1s then eight 0s, one done
    done_cnt = 0;
    cycle("mid", 1'b1, 8'hFF);
    done_cnt += bus.done;
    for (int i = 0; i < 2; i++) begin
      cycle("mid", 1'b0, 8'h00);
      done_cnt += bus.done;
    end
    cycle("mid", 1'b1, 8'h00);
    done_cnt += bus.done;
    for (int i = 0; i < 9; i++) begin
      cycle("mid", 1'b0, 8'hAA);
      done_cnt += bus.done;
    end
    check_eq("mid.done_cnt", done_cnt, 1);

    // Load held high: each cycle shows the latest MSB
    for (int i = 0; i < 4; i++) cycle("hold", 1'b1, 8'($urandom));
    for (int i = 0; i < 10; i++) cycle("hold_tail", 1'b0, 8'h00);

    // Reset mid-frame on 8'hC3
    cycle("rstmid", 1'b1, 8'hC3);
    for (int i = 0; i < 3; i++) cycle("rstmid", 1'b0, 8'h00);
    async_reset("rstmid");
    for (int i = 0; i < 10; i++) cycle("rstmid_after", 1'b0, 8'h00);

    // Randomized loads with occasional async resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset("rnd");
      end else begin
        cycle("rnd", ($urandom_range(0, 5) == 0), 8'($urandom));
      end
    end
    for (int i = 0; i < 10; i++) cycle("rnd_tail", 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
